// File: rtl/mtl2_key_pkg.sv
// Shared types and constants for the key PIO interrupt master.
package mtl2_key_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_EDGE,
        ST_WAIT_EDGE,
        ST_CLR_EDGE,
        ST_RD_DATA,
        ST_WAIT_DATA,
        ST_PUSH
    } state_e;

    localparam logic [1:0]  ADDR_DATA     = 2'd0;
    localparam logic [1:0]  ADDR_MASK     = 2'd2;
    localparam logic [1:0]  ADDR_EDGE     = 2'd3;
    localparam logic [31:0] EDGE_CLR_DATA = 32'h0000_0003;

    typedef struct packed {
        logic [1:0] edge_bits;
        logic [1:0] level;
    } key_evt_t;

endpackage

// File: rtl/mtl2_key_evt_fifo.sv
// Small synchronous FIFO for key events; push while full is accepted only with a same-cycle pop.
module mtl2_key_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mtl2_key_irq_master.sv
// Avalon-MM master servicing the key PIO: programs the irq mask, then turns each
// irq into an {edge,level} event in a FIFO, counting events lost to a full FIFO.
//
// state      | meaning
// INIT       | write IRQ_MASK to PIO address 2
// IDLE       | wait for irq (only state with busy=0)
// RD_EDGE    | read edge_capture
// WAIT_EDGE  | latch edge_capture read data
// CLR_EDGE   | write edge_capture to clear it
// RD_DATA    | read key level
// WAIT_DATA  | latch key level read data
// PUSH       | push event, or drop and count if FIFO full
module mtl2_key_irq_master
    import mtl2_key_pkg::*;
#(
    parameter logic [1:0] IRQ_MASK   = 2'b11,
    parameter int         FIFO_DEPTH = 4,
    parameter int         DROP_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              irq,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [1:0]        evt_edge,
    output logic [1:0]        evt_level,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);

    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    state_e      state;
    state_e      next_state;
    logic        cs_d;
    logic        wr_n_d;
    logic [1:0]  addr_d;
    logic [31:0] wdata_d;
    logic [1:0]  edge_r;
    logic [1:0]  level_r;
    logic        in_push;
    logic        drop;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    key_evt_t    push_evt;
    key_evt_t    head_evt;
    logic        unused_rd;

    assign unused_rd = &{1'b0, avm_readdata[31:2]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= next_state;
    end

    // Bus outputs are registered from next_state, so INIT lingers until its write is on the bus.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:      if (avm_chipselect) next_state = ST_IDLE;
            ST_IDLE:      if (irq) next_state = ST_RD_EDGE;
            ST_RD_EDGE:   next_state = ST_WAIT_EDGE;
            ST_WAIT_EDGE: next_state = ST_CLR_EDGE;
            ST_CLR_EDGE:  next_state = ST_RD_DATA;
            ST_RD_DATA:   next_state = ST_WAIT_DATA;
            ST_WAIT_DATA: next_state = ST_PUSH;
            ST_PUSH:      next_state = ST_IDLE;
            default:      next_state = ST_INIT;
        endcase
    end

    always_comb begin
        cs_d    = 1'b0;
        wr_n_d  = 1'b1;
        addr_d  = ADDR_DATA;
        wdata_d = '0;
        case (next_state)
            ST_INIT: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = ADDR_MASK;
                wdata_d = {30'b0, IRQ_MASK};
            end
            ST_RD_EDGE: begin
                cs_d   = 1'b1;
                addr_d = ADDR_EDGE;
            end
            ST_CLR_EDGE: begin
                cs_d    = 1'b1;
                wr_n_d  = 1'b0;
                addr_d  = ADDR_EDGE;
                wdata_d = EDGE_CLR_DATA;
            end
            ST_RD_DATA: begin
                cs_d   = 1'b1;
                addr_d = ADDR_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= '0;
            avm_writedata  <= '0;
        end else begin
            avm_chipselect <= cs_d;
            avm_write_n    <= wr_n_d;
            avm_address    <= addr_d;
            avm_writedata  <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_r  <= '0;
            level_r <= '0;
        end else begin
            if (state == ST_WAIT_EDGE) edge_r  <= avm_readdata[1:0];
            if (state == ST_WAIT_DATA) level_r <= avm_readdata[1:0];
        end
    end

    // A spurious irq (no captured edge) produces neither an event nor a drop.
    assign in_push   = (state == ST_PUSH) && (edge_r != 2'b00);
    assign fifo_pop  = evt_valid && evt_ready;
    assign fifo_push = in_push && (!fifo_full || fifo_pop);
    assign drop      = in_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      drop_count <= '0;
        else if (drop && !(&drop_count))   drop_count <= drop_count + DROP_ONE;
    end

    assign push_evt.edge_bits = edge_r;
    assign push_evt.level     = level_r;

    mtl2_key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_evt_t))
    ) u_evt_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_evt),
        .pop       (fifo_pop),
        .pop_data  (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_edge  = head_evt.edge_bits;
    assign evt_level = head_evt.level;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mtl2_key_irq_master.sv
// Bench for mtl2_key_irq_master with a behavioural key PIO slave on the bus.
module tb_mtl2_key_irq_master;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] rdata_q;
    logic        irq;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_edge;
    logic [1:0]  evt_level;
    logic [7:0]  drop_count;
    logic        busy;

    logic [1:0]  in_port;
    logic [1:0]  in_d;
    logic [1:0]  edge_cap;
    logic [1:0]  pio_mask;
    logic        irq_force;

    int n_chk;
    int n_fail;

    typedef struct packed {
        logic        wr_n;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } acc_t;
    acc_t log_q[$];

    typedef struct {
        logic [1:0] keys;
        logic [1:0] exp_edge;
        logic [1:0] exp_level;
        int         exp_lat;
    } vec_t;
    vec_t vecs[3];

    mtl2_key_irq_master #(
        .IRQ_MASK   (2'b11),
        .FIFO_DEPTH (4),
        .DROP_W     (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (rdata_q),
        .irq            (irq),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_edge       (evt_edge),
        .evt_level      (evt_level),
        .drop_count     (drop_count),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key PIO slave: falling-edge capture, any write to 3 clears it, read latency 1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_d     <= 2'b11;
            edge_cap <= 2'b00;
            pio_mask <= 2'b00;
            rdata_q  <= '0;
        end else begin
            in_d <= in_port;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
                edge_cap <= 2'b00;
            else
                edge_cap <= edge_cap | (in_d & ~in_port);
            if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
                pio_mask <= avm_writedata[1:0];
            if (avm_chipselect && avm_write_n) begin
                case (avm_address)
                    2'd0:    rdata_q <= {30'b0, in_port};
                    2'd2:    rdata_q <= {30'b0, pio_mask};
                    2'd3:    rdata_q <= {30'b0, edge_cap};
                    default: rdata_q <= '0;
                endcase
            end
        end
    end

    assign irq = irq_force | (|(edge_cap & pio_mask));

    always @(negedge clk) begin
        if (avm_chipselect) log_q.push_back({avm_write_n, avm_address, avm_writedata});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_acc(input string name, input int idx, input logic wr_n,
                           input logic [1:0] addr, input logic [31:0] wdata);
        acc_t e;
        e = {wr_n, addr, wdata};
        if (idx < log_q.size()) begin
            chk(name, {29'b0, log_q[idx]}, {29'b0, e});
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: access %0d missing, required=%0h", name, idx, e);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int i;
        i = 0;
        while (busy !== lvl && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk(name, {63'b0, busy}, {63'b0, lvl});
    endtask

    task automatic press(input logic [1:0] keys);
        in_port = keys;
        @(negedge clk);
        wait_busy(1'b1, "press_start");
        wait_busy(1'b0, "press_done");
        in_port = 2'b11;
        @(negedge clk);
    endtask

    task automatic pop_chk(input string name, input logic [1:0] e, input logic [1:0] l);
        chk({name, "_valid"}, {63'b0, evt_valid}, 64'd1);
        chk({name, "_edge"},  {62'b0, evt_edge},  {62'b0, e});
        chk({name, "_level"}, {62'b0, evt_level}, {62'b0, l});
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int lat;

        n_chk = 0;
        n_fail = 0;
        reset_n = 1'b0;
        in_port = 2'b11;
        evt_ready = 1'b0;
        irq_force = 1'b0;

        vecs[0] = '{keys: 2'b10, exp_edge: 2'b01, exp_level: 2'b10, exp_lat: 7};
        vecs[1] = '{keys: 2'b01, exp_edge: 2'b10, exp_level: 2'b01, exp_lat: 7};
        vecs[2] = '{keys: 2'b00, exp_edge: 2'b11, exp_level: 2'b00, exp_lat: 7};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs",    {63'b0, avm_chipselect}, 64'd0);
        chk("rst_wr_n",  {63'b0, avm_write_n},    64'd1);
        chk("rst_addr",  {62'b0, avm_address},    64'd0);
        chk("rst_wdata", {32'b0, avm_writedata},  64'd0);
        chk("rst_valid", {63'b0, evt_valid},      64'd0);
        chk("rst_edge",  {62'b0, evt_edge},       64'd0);
        chk("rst_level", {62'b0, evt_level},      64'd0);
        chk("rst_drop",  {56'b0, drop_count},     64'd0);
        chk("rst_busy",  {63'b0, busy},           64'd1);

        // INIT mask write, then idle
        log_q.delete();
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("init_nacc", log_q.size(), 64'd1);
        chk_acc("init_acc", 0, 1'b0, 2'd2, 32'd3);
        chk("init_cs",   {63'b0, avm_chipselect}, 64'd0);
        chk("init_busy", {63'b0, busy},           64'd0);

        // Table: one press per vector, check bus sequence, latency and head entry
        for (int v = 0; v < 3; v++) begin
            log_q.delete();
            in_port = vecs[v].keys;
            found = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (irq) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("vec_irq", {63'b0, found}, 64'd1);
            lat = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                lat++;
                if (evt_valid) break;
            end
            chk("vec_latency", lat, vecs[v].exp_lat);
            chk("vec_nacc", log_q.size(), 64'd3);
            chk_acc("vec_acc_rd_edge",  0, 1'b1, 2'd3, 32'd0);
            chk_acc("vec_acc_clr_edge", 1, 1'b0, 2'd3, 32'd3);
            chk_acc("vec_acc_rd_data",  2, 1'b1, 2'd0, 32'd0);
            pop_chk("vec_evt", vecs[v].exp_edge, vecs[v].exp_level);
            chk("vec_empty", {63'b0, evt_valid}, 64'd0);
            wait_busy(1'b0, "vec_idle");
            in_port = 2'b11;
            @(negedge clk);
        end

        // Spurious irq: full access sequence, no push, no drop
        log_q.delete();
        irq_force = 1'b1;
        @(negedge clk);
        irq_force = 1'b0;
        wait_busy(1'b0, "spur_idle");
        chk("spur_nacc", log_q.size(), 64'd3);
        chk_acc("spur_acc_clr", 1, 1'b0, 2'd3, 32'd3);
        chk("spur_valid", {63'b0, evt_valid},  64'd0);
        chk("spur_drop",  {56'b0, drop_count}, 64'd0);

        // Overflow: five presses into a 4-deep FIFO
        repeat (5) press(2'b10);
        chk("ovf_valid", {63'b0, evt_valid},  64'd1);
        chk("ovf_drop",  {56'b0, drop_count}, 64'd1);

        // Full FIFO with pop during PUSH: both happen, no drop
        in_port = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (avm_chipselect && avm_write_n && avm_address == 2'd0) begin
                found = 1'b1;
                break;
            end
        end
        chk("pp_rd_data_seen", {63'b0, found}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk("pp_drop",  {56'b0, drop_count}, 64'd1);
        chk("pp_valid", {63'b0, evt_valid},  64'd1);
        wait_busy(1'b0, "pp_idle");
        in_port = 2'b11;
        @(negedge clk);
        pop_chk("pp_drain0", 2'b01, 2'b10);
        pop_chk("pp_drain1", 2'b01, 2'b10);
        pop_chk("pp_drain2", 2'b01, 2'b10);
        pop_chk("pp_drain3", 2'b10, 2'b01);
        chk("pp_empty", {63'b0, evt_valid}, 64'd0);

        // Saturation of drop_count
        repeat (4) press(2'b10);
        chk("sat_fill_drop", {56'b0, drop_count}, 64'd1);
        repeat (254) press(2'b10);
        chk("sat_drop_255", {56'b0, drop_count}, 64'd255);
        press(2'b10);
        chk("sat_drop_hold", {56'b0, drop_count}, 64'd255);

        // Async reset during CLR_EDGE
        in_port = 2'b10;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("rr_clr_seen", {63'b0, found}, 64'd1);
        chk("rr_full_before", {63'b0, evt_valid}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rr_cs",    {63'b0, avm_chipselect}, 64'd0);
        chk("rr_valid", {63'b0, evt_valid},      64'd0);
        chk("rr_drop",  {56'b0, drop_count},     64'd0);
        chk("rr_busy",  {63'b0, busy},           64'd1);
        in_port = 2'b11;
        repeat (2) @(negedge clk);
        log_q.delete();
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_acc("rr_init_acc", 0, 1'b0, 2'd2, 32'd3);
        chk("rr_nacc", log_q.size(), 64'd1);
        chk("rr_idle", {63'b0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
